// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency-meter gate controller:
// state encoding, range codes and the gate-length calculation.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_SETTLE,
    ST_EVAL,
    ST_LATCH
  } state_t;

  localparam int unsigned TMR_W = 30;

  localparam logic [1:0] RNG_10MS  = 2'd0;
  localparam logic [1:0] RNG_100MS = 2'd1;
  localparam logic [1:0] RNG_1S    = 2'd2;
  localparam logic [1:0] RNG_10S   = 2'd3;
  localparam logic [1:0] RNG_RESET = RNG_1S;

  // Gate length in clk cycles: one 10 ms base period scaled by 10^range.
  function automatic logic [TMR_W-1:0] gate_len(input int unsigned clk_hz,
                                                input logic [1:0]  rng);
    logic [31:0] w_base;
    logic [31:0] w_len;
    w_base = clk_hz / 32'd100;
    case (rng)
      RNG_10MS:  w_len = w_base;
      RNG_100MS: w_len = w_base * 32'd10;
      RNG_1S:    w_len = w_base * 32'd100;
      default:   w_len = w_base * 32'd1000;
    endcase
    return w_len[TMR_W-1:0];
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// Loadable down counter with a zero flag; one instance times the clear,
// gate and settle phases of a measurement.
module gate_timer #(
  parameter int unsigned W = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Saturates at zero so a phase that overstays never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-time sequencer for a reciprocal-free frequency counter: clears the
// counter, opens the gate for the selected time, auto-ranges and latches.
module freq_gate_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned CLR_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_cont,
  input  logic [1:0] i_range_sel,
  input  logic       i_auto_rng,
  input  logic       i_cnt_ovf,
  input  logic       i_cnt_low,
  output logic       o_gate,
  output logic       o_cnt_clr,
  output logic       o_latch,
  output logic       o_busy,
  output logic [1:0] o_range_out,
  output logic       o_ovf_flag
);

  import freq_meter_pkg::*;

  localparam logic [TMR_W-1:0] CLR_LOAD    = TMR_W'(CLR_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [1:0]       r_range;
  logic [1:0]       w_nextRange;
  logic             r_ovfFlag;
  logic             w_nextOvf;
  logic             r_gate;
  logic             r_cntClr;
  logic             r_latch;
  logic             r_busy;
  logic             r_rdy;
  logic             w_tmrLoad;
  logic [TMR_W-1:0] w_tmrVal;
  logic             w_tmrZero;

  gate_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmrLoad),
    .i_load_val (w_tmrVal),
    .o_zero     (w_tmrZero)
  );

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_range   <= RNG_RESET;
      r_ovfFlag <= 1'b0;
      r_gate    <= 1'b0;
      r_cntClr  <= 1'b0;
      r_latch   <= 1'b0;
      r_busy    <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_range   <= w_nextRange;
      r_ovfFlag <= w_nextOvf;
      r_gate    <= (w_nextState == ST_GATE);
      r_cntClr  <= (w_nextState == ST_CLEAR);
      r_latch   <= (w_nextState == ST_LATCH);
      r_busy    <= (w_nextState != ST_IDLE);
      r_rdy     <= 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextRange = r_range;
    w_nextOvf   = r_ovfFlag;
    w_tmrLoad   = 1'b0;
    w_tmrVal    = CLR_LOAD;
    case (r_state)
      ST_IDLE: begin
        // r_rdy holds off requests until the second edge after reset release.
        if (r_rdy && (i_start || i_cont)) begin
          w_nextState = ST_CLEAR;
          w_tmrLoad   = 1'b1;
          w_tmrVal    = CLR_LOAD;
          if (!i_auto_rng) begin
            w_nextRange = i_range_sel;
          end
        end
      end
      ST_CLEAR: begin
        if (w_tmrZero) begin
          w_nextState = ST_GATE;
          w_tmrLoad   = 1'b1;
          w_tmrVal    = gate_len(CLK_HZ, r_range) - TMR_W'(1);
        end
      end
      ST_GATE: begin
        if (w_tmrZero) begin
          w_nextState = ST_SETTLE;
          w_tmrLoad   = 1'b1;
          w_tmrVal    = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (w_tmrZero) begin
          w_nextState = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (i_auto_rng && i_cnt_ovf && (r_range != RNG_10MS)) begin
          w_nextState = ST_CLEAR;
          w_nextRange = r_range - 2'd1;
          w_tmrLoad   = 1'b1;
          w_tmrVal    = CLR_LOAD;
        end else if (i_auto_rng && !i_cnt_ovf && i_cnt_low && (r_range != RNG_10S)) begin
          w_nextState = ST_CLEAR;
          w_nextRange = r_range + 2'd1;
          w_tmrLoad   = 1'b1;
          w_tmrVal    = CLR_LOAD;
        end else begin
          w_nextState = ST_LATCH;
          w_nextOvf   = i_cnt_ovf;
        end
      end
      ST_LATCH: begin
        if (i_cont) begin
          w_nextState = ST_CLEAR;
          w_tmrLoad   = 1'b1;
          w_tmrVal    = CLR_LOAD;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign o_gate      = r_gate;
  assign o_cnt_clr   = r_cntClr;
  assign o_latch     = r_latch;
  assign o_busy      = r_busy;
  assign o_range_out = r_range;
  assign o_ovf_flag  = r_ovfFlag;

endmodule

// File: doc/freq_gate_ctrl.md
FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: clock `clk`; reset `rst_n`, asynchronous, active-low.
REQ-002 Parameter CLK_HZ, default 50_000_000: clk frequency in Hz; SHALL be a multiple of 100.
REQ-003 Parameter CLR_CYC, default 4: number of clk cycles that cnt_clr is held.
REQ-004 Parameter SETTLE_CYC, default 4: number of clk cycles after gate closes before the count is evaluated.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request to begin measuring.
REQ-008 cont  in  1  continuous mode; re-arms after each latch.
REQ-009 range_sel  in  2  manual gate time: 0=10 ms, 1=100 ms, 2=1 s, 3=10 s.
REQ-010 auto_rng  in  1  auto-range enable.
REQ-011 cnt_ovf  in  1  BCD counter saturated at 99999999; already synchronous to clk.
REQ-012 cnt_low  in  1  count is below 10% of full scale; already synchronous to clk.
REQ-013 gate  out  1  count enable for the input-frequency counter.
REQ-014 cnt_clr  out  1  clear for the input-frequency counter.
REQ-015 latch  out  1  one-cycle pulse that captures the count into the display registers.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 range_out  out  2  range currently in use.
REQ-018 ovf_flag  out  1  overflow status of the last latched result.

Function
REQ-019 States SHALL be IDLE, CLEAR, GATE, SETTLE, EVAL and LATCH; all outputs SHALL be registered.
REQ-020 IDLE->CLEAR SHALL occur on the edge where start=1, or where cont=1; busy SHALL rise on the next cycle.
REQ-021 On entry to CLEAR from IDLE, range_out SHALL load range_sel when auto_rng=0, and SHALL keep its current value when auto_rng=1.
REQ-022 CLEAR SHALL hold cnt_clr=1 for exactly CLR_CYC cycles and then go to GATE.
REQ-023 GATE SHALL hold gate=1 for exactly CLK_HZ/100 * 10^range_out cycles and then go to SETTLE; gate=0 in all other states.
REQ-024 The gate-length counter SHALL be 30 bits wide and SHALL count down from length-1 to 0 with no wrap.
REQ-025 SETTLE SHALL last SETTLE_CYC cycles and then go to EVAL.
REQ-026 EVAL SHALL last 1 cycle and SHALL sample cnt_ovf and cnt_low, with auto_rng as follows:
- auto_rng=1, cnt_ovf=1, range_out>0: decrement range_out, go to CLEAR, no latch.
- auto_rng=1, cnt_ovf=0, cnt_low=1, range_out<3: increment range_out, go to CLEAR, no latch.
- Otherwise: go to LATCH.
- cnt_ovf takes priority over cnt_low.
REQ-027 LATCH SHALL assert latch=1 for 1 cycle and SHALL set ovf_flag=cnt_ovf sampled in EVAL; the next state SHALL be CLEAR if cont=1, otherwise IDLE.
REQ-028 start while busy=1 SHALL be ignored; cont deasserted mid-measurement SHALL let the current measurement finish, then go to IDLE.
REQ-029 range_sel changes while busy=1 SHALL NOT affect range_out until the next IDLE->CLEAR.
REQ-030 In manual mode, cnt_ovf=1 SHALL still latch, with ovf_flag=1.

Reset
REQ-031 While rst_n=0, the block SHALL force: state=IDLE, gate=0, cnt_clr=0, latch=0, busy=0, ovf_flag=0, range_out=2, counters=0. This SHALL take effect asynchronously, including mid-GATE.
REQ-032 Reset release SHALL be synchronous; the first start SHALL be honoured no earlier than the second clk edge after rst_n rises.

Structure
REQ-033 Package freq_meter_pkg SHALL hold:
- the state enumeration;
- the range encoding constants;
- a gate-length function of CLK_HZ and range.
REQ-034 One sub-module, gate_timer (loadable 30-bit down counter with a zero flag), SHALL be shared by the CLEAR, GATE and SETTLE phases.

Verification (CLK_HZ=1000, CLR_CYC=2, SETTLE_CYC=3)
REQ-035 Single shot: range_sel=1, start pulse -> cnt_clr high for 2 cycles, gate high for exactly 100 cycles, 3 idle cycles, 1 EVAL cycle, latch pulse; busy falls the next cycle.
REQ-036 Continuous: cont=1, range 0 -> latch pulses every 2+10+3+1+1=17 cycles; cont dropped mid-GATE -> exactly one more latch, then IDLE.
REQ-037 Auto-range down: auto_rng=1, range_out=2, cnt_ovf=1 in EVAL -> no latch, range_out=1, new gate of 100 cycles; if cnt_ovf=1 persists at range 0 -> latch with ovf_flag=1.
REQ-038 Auto-range up: cnt_low=1 at range 2 -> range_out=3, gate of 10000 cycles, then latch with cnt_low=0.
REQ-039 Reset mid-GATE: rst_n low at cycle 50 of the gate -> gate=0 immediately, range_out=2, busy=0; a start after release runs a clean measurement.
REQ-040 Ignored inputs: start pulsed and range_sel changed during GATE -> gate length unchanged and no extra measurement.
